// File: rtl/fft_output_serializer.sv
// fft_output_serializer: captures one frame of parallel FFT results and streams it out one word per valid/ready beat.
// Define BITREV_ORDER_EN to read the buffer in bit-reversed order so bins leave in natural order.
module fft_output_serializer #(
    parameter int p_outputBits = 20,
    parameter int p_points     = 32
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [p_points*p_outputBits-1:0] i_c,
    input  logic                             i_valid,
    output logic                             o_in_ready,
    output logic [p_outputBits-1:0]          o_data,
    output logic [$clog2(p_points)-1:0]      o_index,
    output logic                             o_valid,
    output logic                             o_last,
    input  logic                             i_ready,
    output logic                             o_overrun,
    output logic [15:0]                      o_frame_cnt
);
    localparam int IW = $clog2(p_points);
    typedef enum logic {IDLE, SEND} state_t;
    state_t                           state_q, state_d;
    logic [IW-1:0]                    rd_ptr_q, rd_ptr_d, addr;
    logic [15:0]                      frame_cnt_q, frame_cnt_d;
    logic                             overrun_q, overrun_d;
    logic [p_points*p_outputBits-1:0] frame_q, frame_d;
    logic                             send, beat, last;
`ifdef BITREV_ORDER_EN
    function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] p);
        logic [IW-1:0] r;
        for (int i = 0; i < IW; i++) r[i] = p[IW-1-i];
        return r;
    endfunction
`endif
    always_comb begin
        send = state_q == SEND;
        last = rd_ptr_q == IW'(p_points - 1);
        beat = send && i_ready;
`ifdef BITREV_ORDER_EN
        addr = bitrev(rd_ptr_q);
`else
        addr = rd_ptr_q;
`endif
    end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
        end
    end
    // Buffer contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge CLK) frame_q <= frame_d;
    always_comb begin
        state_d = send ? ((beat && last) ? IDLE : SEND) : (i_valid ? SEND : IDLE);
    end
    always_comb begin
        rd_ptr_d    = send ? rd_ptr_q + IW'(beat) : '0;
        frame_cnt_d = frame_cnt_q + 16'(beat && last);
        overrun_d   = overrun_q | (send & i_valid);
        frame_d     = (!send && i_valid) ? i_c : frame_q;
    end
    always_comb begin
        o_in_ready  = !send;
        o_valid     = send;
        o_last      = send && last;
        o_index     = send ? rd_ptr_q : '0;
        o_data      = send ? frame_q[int'(addr)*p_outputBits +: p_outputBits] : '0;
        o_overrun   = overrun_q;
        o_frame_cnt = frame_cnt_q;
    end
endmodule
